// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared encodings, FSM states and saturating truncation for matmul_accel_avmm
package matmul_pkg;

    // Region select carried in the two top bits of the word address.
    typedef enum logic [1:0] {
        RGN_REG = 2'b00,
        RGN_A   = 2'b01,
        RGN_B   = 2'b10,
        RGN_C   = 2'b11
    } region_e;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_DIMS   = 2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_SAT  = 2;
    localparam int ST_ERR  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] value;
        logic        clip;
    } sat_res_t;

    // Arithmetic shift right by frac_w (rounds toward -inf), then clamp to a
    // data_w-bit signed range. The accumulator is passed sign-extended to 64 bits
    // so one function serves every parameterisation.
    function automatic sat_res_t sat_trunc(input logic signed [63:0] acc,
                                           input int data_w,
                                           input int frac_w);
        sat_res_t          res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = acc >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        res.clip = 1'b1;
        if (r > hi) begin
            res.value = hi[31:0];
        end else if (r < lo) begin
            res.value = lo[31:0];
        end else begin
            res.value = r[31:0];
            res.clip  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_accel_avmm_mac.sv
// rtl/matmul_accel_avmm_mac.sv - signed multiply-accumulate with saturating truncation output
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr, en        : clear accumulator (wins over en), accumulate a*b
//   a, b           : signed operands, already registered by the buffer read ports
//   result, clip   : accumulator >>> FRAC_W saturated to DATA_W, and clip flag
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              clip
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    sat_res_t                   sr;
    logic                       unused_bits;

    assign prod = $signed(a) * $signed(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    assign sr          = sat_trunc(64'(acc), DATA_W, FRAC_W);
    assign result      = sr.value[DATA_W-1:0];
    assign clip        = sr.clip;
    assign unused_bits = ^sr.value[31:DATA_W];

endmodule

// File: rtl/matmul_accel_avmm.sv
// rtl/matmul_accel_avmm.sv - Avalon-MM matrix multiply engine C = A*B with runtime dimensions
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   avs_address            : word address, [AW-1:AW-2] region, low bits element/register index
//   avs_write/avs_writedata: register and buffer writes
//   avs_read/avs_readdata  : reads with fixed latency 1, elements sign-extended
//   irq                    : done & irq_en
module matmul_accel_avmm
    import matmul_pkg::*;
#(
    parameter int  N      = 4,
    parameter int  DATA_W = 16,
    parameter int  FRAC_W = 8,
    localparam int IW     = $clog2(N * N),
    localparam int AW     = 2 + IW,
    localparam int ACC_W  = 2 * DATA_W + $clog2(N)
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic          avs_read,
    output logic [31:0]   avs_readdata,
    output logic          irq
);

    localparam logic [7:0] NMAX = 8'(N);

    logic [DATA_W-1:0] a_mem [N*N];
    logic [DATA_W-1:0] b_mem [N*N];
    logic [DATA_W-1:0] c_mem [N*N];

    region_e       region;
    logic [IW-1:0] offset;
    logic          ctrl_wr, dims_wr, a_wr, b_wr, start_req, dims_ok;

    state_e state, state_nxt;
    logic   busy, done, sat, err, irq_en;
    logic [7:0] m_dim, k_dim, p_dim;
    logic [7:0] i_cnt, j_cnt, k_cnt;

    logic [IW-1:0]     a_idx, b_idx, c_idx;
    logic [DATA_W-1:0] a_q, b_q;
    logic              valid_q;
    logic              mac_clr, c_we, clip;
    logic [DATA_W-1:0] mac_result;
    logic              unused_bits;

    assign region    = region_e'(avs_address[AW-1:AW-2]);
    assign offset    = avs_address[IW-1:0];
    assign ctrl_wr   = avs_write && (region == RGN_REG) && (offset == IW'(REG_CTRL));
    assign dims_wr   = avs_write && (region == RGN_REG) && (offset == IW'(REG_DIMS));
    assign a_wr      = avs_write && (region == RGN_A);
    assign b_wr      = avs_write && (region == RGN_B);
    assign start_req = ctrl_wr && avs_writedata[CTRL_START];
    assign dims_ok   = (m_dim != 8'd0) && (m_dim <= NMAX) &&
                       (k_dim != 8'd0) && (k_dim <= NMAX) &&
                       (p_dim != 8'd0) && (p_dim <= NMAX);

    assign a_idx = IW'(i_cnt * N + k_cnt);
    assign b_idx = IW'(k_cnt * N + j_cnt);
    assign c_idx = IW'(i_cnt * N + j_cnt);

    assign irq         = done & irq_en;
    assign unused_bits = ^avs_writedata[31:24];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        c_we      = 1'b0;
        unique case (state)
            S_IDLE: begin
                mac_clr = 1'b1;
                if (start_req && dims_ok) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (k_cnt == k_dim - 8'd1) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_WRITE;
            S_WRITE: begin
                mac_clr = 1'b1;
                c_we    = 1'b1;
                if ((i_cnt == m_dim - 8'd1) && (j_cnt == p_dim - 8'd1)) state_nxt = S_DONE;
                else                                                    state_nxt = S_RUN;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Row-major walk: k inner, then j, then i.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            i_cnt   <= '0;
            j_cnt   <= '0;
            k_cnt   <= '0;
            valid_q <= 1'b0;
        end else begin
            // A read issued in RUN lands in a_q/b_q one cycle later.
            valid_q <= (state == S_RUN);
            case (state)
                S_IDLE: begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    k_cnt <= '0;
                end
                S_RUN: k_cnt <= k_cnt + 8'd1;
                S_WRITE: begin
                    k_cnt <= '0;
                    if (j_cnt == p_dim - 8'd1) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 8'd1;
                    end else begin
                        j_cnt <= j_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Later statements take precedence: clr is applied before a same-write start.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            sat    <= 1'b0;
            err    <= 1'b0;
            irq_en <= 1'b0;
            m_dim  <= '0;
            k_dim  <= '0;
            p_dim  <= '0;
        end else begin
            if ((a_wr || b_wr || dims_wr) && busy) err <= 1'b1;
            if (dims_wr && !busy) begin
                m_dim <= avs_writedata[7:0];
                k_dim <= avs_writedata[15:8];
                p_dim <= avs_writedata[23:16];
            end
            if (ctrl_wr) begin
                irq_en <= avs_writedata[CTRL_IRQ_EN];
                if (avs_writedata[CTRL_CLR]) begin
                    done <= 1'b0;
                    sat  <= 1'b0;
                    err  <= 1'b0;
                end
            end
            if ((state == S_IDLE) && start_req) begin
                if (!dims_ok) begin
                    err <= 1'b1;
                end else begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    sat  <= 1'b0;
                end
            end
            if ((state == S_WRITE) && clip) sat <= 1'b1;
            if (state == S_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Buffers: bus writes A/B and reads all three; the engine reads A/B and writes C.
    always_ff @(posedge clk_clk) begin
        if (a_wr && !busy) a_mem[offset] <= avs_writedata[DATA_W-1:0];
        if (b_wr && !busy) b_mem[offset] <= avs_writedata[DATA_W-1:0];
        if (c_we)          c_mem[c_idx]  <= mac_result;
        a_q <= a_mem[a_idx];
        b_q <= b_mem[b_idx];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            unique case (region)
                RGN_REG: begin
                    if (offset == IW'(REG_CTRL))
                        avs_readdata <= {30'd0, irq_en, 1'b0};
                    else if (offset == IW'(REG_STATUS))
                        avs_readdata <= {28'd0, err, sat, done, busy};
                    else if (offset == IW'(REG_DIMS))
                        avs_readdata <= {8'd0, p_dim, k_dim, m_dim};
                    else
                        avs_readdata <= '0;
                end
                RGN_A:   avs_readdata <= 32'($signed(a_mem[offset]));
                RGN_B:   avs_readdata <= 32'($signed(b_mem[offset]));
                RGN_C:   avs_readdata <= 32'($signed(c_mem[offset]));
                default: avs_readdata <= '0;
            endcase
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .clr    (mac_clr),
        .en     (valid_q),
        .a      (a_q),
        .b      (b_q),
        .result (mac_result),
        .clip   (clip)
    );

endmodule

// File: tb/tb_matmul_accel_avmm.sv
// tb/tb_matmul_accel_avmm.sv - self-checking bench for matmul_accel_avmm against a matrix reference model
module tb_matmul_accel_avmm;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [5:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int start_cyc;
    int a_m [16];
    int b_m [16];
    logic [31:0] rd;

    matmul_accel_avmm dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] rg, input int off, input logic [31:0] d);
        @(negedge clk_clk);
        avs_address   = {rg, 4'(off)};
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] rg, input int off, output logic [31:0] d);
        @(negedge clk_clk);
        avs_address = {rg, 4'(off)};
        avs_read    = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // Upper write-data bits are randomised; only the low 16 bits are element data.
    task automatic load_ab();
        for (int x = 0; x < 16; x++) begin
            bus_write(2'b01, x, {16'($urandom), 16'(a_m[x])});
            bus_write(2'b10, x, {16'($urandom), 16'(b_m[x])});
        end
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int x = 0; x < 16; x++) begin
            a_m[x] = int'($urandom_range(hi - lo)) + lo;
            b_m[x] = int'($urandom_range(hi - lo)) + lo;
        end
    endtask

    task automatic go(input int m, input int k, input int p);
        bus_write(2'b00, 2, {8'd0, 8'(p), 8'(k), 8'(m)});
        bus_write(2'b00, 0, 32'h3);
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        while (!irq && (cyc - start_cyc) < 2000) begin
            @(posedge clk_clk);
            #1;
        end
        chk(tag, 32'(cyc - start_cyc), 32'(exp_lat));
    endtask

    // Reference: plain integer matrix product, Q8.8 truncation toward -inf, clamp.
    task automatic check_c(input string tag, input int m, input int k, input int p, input bit exp_err);
        logic [31:0] exp_c [16];
        bit          exp_sat;
        longint      s;
        exp_sat = 1'b0;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < p; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++)
                    s += longint'(a_m[i*4+kk]) * longint'(b_m[kk*4+j]);
                s = s >>> 8;
                if (s > 32767) begin
                    s = 32767;
                    exp_sat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768;
                    exp_sat = 1'b1;
                end
                exp_c[i*4+j] = 32'(s);
            end
        end
        bus_read(2'b00, 1, rd);
        chk({tag, "_status"}, rd, {28'd0, exp_err, exp_sat, 1'b1, 1'b0});
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < p; j++) begin
                bus_read(2'b11, i*4+j, rd);
                chk($sformatf("%s_c%0d%0d", tag, i, j), rd, exp_c[i*4+j]);
            end
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        bus_read(2'b00, 1, rd); chk("rst_status", rd, 32'h0);
        bus_read(2'b00, 0, rd); chk("rst_ctrl", rd, 32'h0);
        bus_read(2'b00, 2, rd); chk("rst_dims", rd, 32'h0);

        // Identity
        for (int x = 0; x < 16; x++) begin a_m[x] = 0; b_m[x] = 0; end
        a_m[0] = 'h100; a_m[1] = 'h200; a_m[4] = 'h300; a_m[5] = 'h400;
        b_m[0] = 'h100; b_m[5] = 'h100;
        load_ab();
        go(2, 2, 2);
        wait_done("lat_ident", 17);
        check_c("ident", 2, 2, 2, 1'b0);
        bus_read(2'b00, 2, rd); chk("dims_rb", rd, 32'h00020202);

        // Non-square
        for (int x = 0; x < 16; x++) begin a_m[x] = 'h100; b_m[x] = 'h80; end
        load_ab();
        go(2, 3, 4);
        wait_done("lat_nsq", 41);
        check_c("nsq", 2, 3, 4, 1'b0);
        bus_read(2'b11, 7, rd); chk("nsq_c13_abs", rd, 32'h180);

        // Saturation, then negative result sign extension
        for (int x = 0; x < 16; x++) begin a_m[x] = 'h7FFF; b_m[x] = 'h7FFF; end
        load_ab();
        go(4, 4, 4);
        wait_done("lat_sat", 97);
        check_c("sat", 4, 4, 4, 1'b0);
        a_m[0] = -256; b_m[0] = 256;
        load_ab();
        go(1, 1, 1);
        wait_done("lat_neg", 4);
        check_c("neg", 1, 1, 1, 1'b0);
        bus_read(2'b11, 0, rd); chk("neg_raw", rd, 32'hFFFFFF00);

        bus_read(2'b00, 3, rd); chk("unused_reg3", rd, 32'h0);
        bus_read(2'b00, 9, rd); chk("unused_reg9", rd, 32'h0);
        bus_write(2'b11, 0, 32'h1234);
        bus_read(2'b11, 0, rd); chk("c_write_ignored", rd, 32'hFFFFFF00);

        // Busy protection
        fill_rand(-768, 768);
        load_ab();
        go(4, 4, 4);
        bus_read(2'b00, 1, rd); chk("busy_set", rd, 32'h1);
        bus_write(2'b01, 0, 32'h5555);
        bus_write(2'b00, 2, 32'h00010101);
        bus_write(2'b00, 0, 32'h3);
        wait_done("lat_busy", 97);
        check_c("busy", 4, 4, 4, 1'b1);
        bus_read(2'b01, 0, rd); chk("a00_kept", rd, 32'(a_m[0]));
        bus_read(2'b00, 2, rd); chk("dims_kept", rd, 32'h00040404);
        repeat (120) @(posedge clk_clk);
        #1;
        bus_read(2'b00, 1, rd); chk("single_done", rd, 32'hA);
        bus_write(2'b00, 0, 32'h6);
        chk("irq_clr", 32'(irq), 32'h0);
        bus_read(2'b00, 1, rd); chk("clr_status", rd, 32'h0);

        // Invalid dimensions
        bus_write(2'b00, 2, 32'h00020002);
        bus_write(2'b00, 0, 32'h3);
        repeat (3) @(posedge clk_clk);
        bus_read(2'b00, 1, rd); chk("k0_err", rd, 32'h8);
        bus_write(2'b00, 0, 32'h6);
        bus_read(2'b00, 1, rd); chk("k0_clr", rd, 32'h0);
        bus_write(2'b00, 2, 32'h00040405);
        bus_write(2'b00, 0, 32'h7);
        repeat (3) @(posedge clk_clk);
        bus_read(2'b00, 1, rd); chk("m5_err", rd, 32'h8);
        chk("m5_irq", 32'(irq), 32'h0);
        bus_write(2'b00, 0, 32'h6);
        bus_read(2'b00, 1, rd); chk("m5_clr", rd, 32'h0);

        // Interrupt then reset mid-run
        fill_rand(-768, 768);
        load_ab();
        go(2, 3, 2);
        wait_done("lat_irq", 21);
        chk("irq_set", 32'(irq), 32'h1);
        check_c("irq", 2, 3, 2, 1'b0);
        bus_write(2'b00, 0, 32'h6);
        chk("irq_clr2", 32'(irq), 32'h0);
        go(4, 4, 4);
        bus_read(2'b00, 1, rd); chk("busy2", rd, 32'h1);
        repeat (5) @(posedge clk_clk);
        #3;
        reset_reset_n = 1'b0;
        #1;
        chk("arst_rdata", avs_readdata, 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        bus_read(2'b00, 1, rd); chk("arst_status", rd, 32'h0);
        bus_read(2'b00, 0, rd); chk("arst_ctrl", rd, 32'h0);
        bus_read(2'b00, 2, rd); chk("arst_dims", rd, 32'h0);
        fill_rand(-32768, 32767);
        load_ab();
        go(3, 4, 2);
        wait_done("lat_post", 37);
        check_c("post", 3, 4, 2, 1'b0);

        // Random dimensions
        for (int t = 0; t < 4; t++) begin
            int m, k, p;
            m = int'($urandom_range(1, 4));
            k = int'($urandom_range(1, 4));
            p = int'($urandom_range(1, 4));
            fill_rand(-1024, 1024);
            load_ab();
            go(m, k, p);
            wait_done($sformatf("lat_rnd%0d", t), m * p * (k + 2) + 1);
            check_c($sformatf("rnd%0d", t), m, k, p, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
